// File: rtl/data_mem_hs_pkg.sv
// Shared encodings and helpers for the handshaked MEM-stage data memory.
package data_mem_hs_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Number of cells touched by an access; illegal sizes report one cell.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_nbytes = 3'd1;
            SIZE_HALF: size_nbytes = 3'd2;
            SIZE_WORD: size_nbytes = 3'd4;
            default:   size_nbytes = 3'd1;
        endcase
    endfunction

    function automatic logic [3:0] size_byte_en(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_byte_en = 4'b0001;
            SIZE_HALF: size_byte_en = 4'b0011;
            SIZE_WORD: size_byte_en = 4'b1111;
            default:   size_byte_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_hs_load_ext.sv
// Load data extension: assembles four little-endian cells into a word and
// sign/zero-extends byte and half-word loads.
module mem_load_ext
    import data_mem_hs_pkg::*;
#(
    parameter int CELL = 8
) (
    input  logic [CELL-1:0]   byte0,
    input  logic [CELL-1:0]   byte1,
    input  logic [CELL-1:0]   byte2,
    input  logic [CELL-1:0]   byte3,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [4*CELL-1:0] ext_word
);

    logic sign_s;

    // Select extension source: sign comes from the most significant loaded cell.
    always_comb begin
        sign_s   = 1'b0;
        ext_word = '0;
        case (size)
            SIZE_BYTE: begin
                sign_s   = byte0[CELL-1] & ~is_unsigned;
                ext_word = {{(3*CELL){sign_s}}, byte0};
            end
            SIZE_HALF: begin
                sign_s   = byte1[CELL-1] & ~is_unsigned;
                ext_word = {{(2*CELL){sign_s}}, byte1, byte0};
            end
            SIZE_WORD: begin
                sign_s   = 1'b0;
                ext_word = {byte3, byte2, byte1, byte0};
            end
            default: begin
                sign_s   = 1'b0;
                ext_word = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_hs.sv
// Byte-addressed data memory with valid/ready request and response handshakes,
// programmable wait states, alignment/range checking and load extension.
module data_mem_hs
    import data_mem_hs_pkg::*;
#(
    parameter int WORD_LEN      = 32,
    parameter int ADDR_LEN      = 32,
    parameter int MEM_CELL_SIZE = 8,
    parameter int DATA_MEM_SIZE = 1024,
    parameter int WAIT_STATES   = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [1:0]          i_req_size,
    input  logic                i_req_unsigned,
    input  logic [ADDR_LEN-1:0] i_req_addr,
    input  logic [WORD_LEN-1:0] i_req_wdata,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [WORD_LEN-1:0] o_rsp_rdata,
    output logic                o_rsp_err
);

    localparam int                MEM_IDX_W   = (DATA_MEM_SIZE > 1) ? $clog2(DATA_MEM_SIZE) : 1;
    localparam logic [ADDR_LEN:0] MEM_LIMIT_C = (ADDR_LEN+1)'(DATA_MEM_SIZE);
    localparam logic [3:0]        WAIT_INIT_C = 4'(WAIT_STATES);

    logic [MEM_CELL_SIZE-1:0] mem_r [DATA_MEM_SIZE];

    state_e                state_r;
    state_e                state_next_s;
    logic                  req_ready_r;
    logic                  rsp_valid_r;
    logic [WORD_LEN-1:0]   rsp_rdata_r;
    logic                  rsp_err_r;
    logic [3:0]            cnt_r;
    logic                  we_r;
    logic [1:0]            size_r;
    logic                  uns_r;
    logic [ADDR_LEN-1:0]   addr_r;
    logic [WORD_LEN-1:0]   wdata_r;

    logic                  accept_s;
    logic                  commit_s;
    logic                  err_s;
    logic [ADDR_LEN:0]     last_addr_s;
    logic [ADDR_LEN:0]     byte_addr_s [4];
    logic [MEM_CELL_SIZE-1:0] rd_byte_s [4];
    logic [3:0]            be_s;
    logic [WORD_LEN-1:0]   ext_s;

    assign be_s = size_byte_en(size_r);

    // Error check on the latched request; last-address math is one bit wider so it cannot wrap.
    always_comb begin
        err_s       = 1'b0;
        last_addr_s = {1'b0, addr_r} + (ADDR_LEN+1)'(size_nbytes(size_r)) - (ADDR_LEN+1)'(1);
        if (size_r == 2'b11) begin
            err_s = 1'b1;
        end else if ((size_r == SIZE_HALF) && addr_r[0]) begin
            err_s = 1'b1;
        end else if ((size_r == SIZE_WORD) && (addr_r[1:0] != 2'b00)) begin
            err_s = 1'b1;
        end else if (last_addr_s >= MEM_LIMIT_C) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Per-lane cell addresses and guarded reads (lanes past the array end read zero).
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byte_addr_s[k] = {1'b0, addr_r} + (ADDR_LEN+1)'(k);
            if (byte_addr_s[k] < MEM_LIMIT_C) begin
                rd_byte_s[k] = mem_r[byte_addr_s[k][MEM_IDX_W-1:0]];
            end else begin
                rd_byte_s[k] = '0;
            end
        end
    end

    mem_load_ext #(
        .CELL(MEM_CELL_SIZE)
    ) u_load_ext (
        .byte0      (rd_byte_s[0]),
        .byte1      (rd_byte_s[1]),
        .byte2      (rd_byte_s[2]),
        .byte3      (rd_byte_s[3]),
        .size       (size_r),
        .is_unsigned(uns_r),
        .ext_word   (ext_s)
    );

    // Next-state logic and the accept/commit strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_ready_r && i_req_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    commit_s     = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Control state, request latch and registered response; memory is outside this reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            size_r      <= 2'b00;
            uns_r       <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
        end else begin
            state_r     <= state_next_s;
            req_ready_r <= (state_next_s == ST_IDLE);
            rsp_valid_r <= (state_next_s == ST_RESP);
            if (accept_s) begin
                we_r    <= i_req_we;
                size_r  <= i_req_size;
                uns_r   <= i_req_unsigned;
                addr_r  <= i_req_addr;
                wdata_r <= i_req_wdata;
                cnt_r   <= WAIT_INIT_C;
            end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (commit_s) begin
                rsp_err_r   <= err_s;
                rsp_rdata_r <= (err_s || we_r) ? '0 : ext_s;
            end else if ((state_r == ST_RESP) && i_rsp_ready) begin
                rsp_err_r   <= 1'b0;
                rsp_rdata_r <= '0;
            end
        end
    end

    // Store commit: only the enabled low lanes of the latched write data.
    always_ff @(posedge i_clk) begin
        if (commit_s && we_r && !err_s) begin
            for (int k = 0; k < 4; k++) begin
                if (be_s[k]) begin
                    mem_r[byte_addr_s[k][MEM_IDX_W-1:0]] <= wdata_r[k*MEM_CELL_SIZE +: MEM_CELL_SIZE];
                end
            end
        end
    end

    assign o_req_ready = req_ready_r;
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_rdata = rsp_rdata_r;
    assign o_rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_data_mem_hs.sv
// Randomized self-checking bench: two instances (2 and 0 wait states) checked
// every cycle against a transaction-level memory model, plus literal checks.
module tb_data_mem_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_uns = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_ready = 1'b0;

    logic [1:0]        v_s, rr_s;
    logic [1:0]        ready_o, valid_o, err_o;
    logic [1:0][31:0]  rdata_o;

    assign v_s  = sel ? {req_valid, 1'b0} : {1'b0, req_valid};
    assign rr_s = sel ? {rsp_ready, 1'b0} : {1'b0, rsp_ready};

    data_mem_hs #(.WAIT_STATES(2)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v_s[0]), .o_req_ready(ready_o[0]),
        .i_req_we(req_we), .i_req_size(req_size), .i_req_unsigned(req_uns),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_rsp_valid(valid_o[0]),
        .i_rsp_ready(rr_s[0]), .o_rsp_rdata(rdata_o[0]), .o_rsp_err(err_o[0])
    );

    data_mem_hs #(.WAIT_STATES(0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v_s[1]), .o_req_ready(ready_o[1]),
        .i_req_we(req_we), .i_req_size(req_size), .i_req_unsigned(req_uns),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_rsp_valid(valid_o[1]),
        .i_rsp_ready(rr_s[1]), .o_rsp_rdata(rdata_o[1]), .o_rsp_err(err_o[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ws_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    // Behavioural model: byte array per instance plus abstract response timing.
    logic [7:0]  mm [2][1024];
    bit          m_ready [2] = '{0, 0};
    bit          m_busy  [2] = '{0, 0};
    bit          m_resp  [2] = '{0, 0};
    int          m_due   [2] = '{0, 0};
    logic [31:0] m_rdata [2] = '{32'd0, 32'd0};
    bit          m_err   [2] = '{0, 0};
    bit          l_we    [2];
    logic [1:0]  l_size  [2];
    bit          l_uns   [2];
    logic [31:0] l_addr  [2];
    logic [31:0] l_wdata [2];

    task automatic model_access(input int i);
        int nb;
        longint last;
        logic [31:0] val;
        bit sign;
        nb   = (l_size[i] == 2'd0) ? 1 : (l_size[i] == 2'd1) ? 2 : 4;
        last = longint'(l_addr[i]) + longint'(nb) - 64'sd1;
        m_err[i] = (l_size[i] == 2'd3) || (l_size[i] == 2'd1 && l_addr[i][0]) ||
                   (l_size[i] == 2'd2 && l_addr[i][1:0] != 2'd0) || (last >= 64'sd1024);
        m_rdata[i] = 32'd0;
        if (!m_err[i]) begin
            if (l_we[i]) begin
                for (int k = 0; k < nb; k++) mm[i][int'(l_addr[i]) + k] = 8'((l_wdata[i] >> (8 * k)) & 32'hFF);
            end else begin
                val = 32'd0;
                for (int k = 0; k < nb; k++) val = val | (32'(mm[i][int'(l_addr[i]) + k]) << (8 * k));
                sign = mm[i][int'(l_addr[i]) + nb - 1][7] && !l_uns[i];
                if (sign && nb == 1) val = val | 32'hFFFFFF00;
                if (sign && nb == 2) val = val | 32'hFFFF0000;
                m_rdata[i] = val;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    m_ready[i] = 0; m_busy[i] = 0; m_resp[i] = 0; m_rdata[i] = 32'd0; m_err[i] = 0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (m_resp[i]) begin
                        if (rr_s[i]) begin m_resp[i] = 0; m_ready[i] = 1; end
                    end else if (m_busy[i]) begin
                        m_due[i]--;
                        if (m_due[i] == 0) begin m_busy[i] = 0; m_resp[i] = 1; model_access(i); end
                    end else if (m_ready[i] && v_s[i]) begin
                        l_we[i] = req_we; l_size[i] = req_size; l_uns[i] = req_uns;
                        l_addr[i] = req_addr; l_wdata[i] = req_wdata;
                        m_busy[i] = 1; m_due[i] = ws_of(i) + 1; m_ready[i] = 0;
                    end else begin
                        m_ready[i] = 1;
                    end
                end
            end
        end
    end

    // Cycle compare against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    chk($sformatf("rst_ready%0d", i), 32'(ready_o[i]), 32'd0);
                    chk($sformatf("rst_valid%0d", i), 32'(valid_o[i]), 32'd0);
                    chk($sformatf("rst_rdata%0d", i), rdata_o[i], 32'd0);
                    chk($sformatf("rst_err%0d", i), 32'(err_o[i]), 32'd0);
                end else begin
                    chk($sformatf("ready%0d", i), 32'(ready_o[i]), 32'(m_ready[i]));
                    chk($sformatf("valid%0d", i), 32'(valid_o[i]), 32'(m_resp[i]));
                    if (m_resp[i]) begin
                        chk($sformatf("rdata%0d", i), rdata_o[i], m_rdata[i]);
                        chk($sformatf("err%0d", i), 32'(err_o[i]), 32'(m_err[i]));
                    end
                end
            end
        end
    end

    function automatic logic cur_ready();
        return sel ? ready_o[1] : ready_o[0];
    endfunction
    function automatic logic cur_valid();
        return sel ? valid_o[1] : valid_o[0];
    endfunction

    task automatic do_txn(input bit we, input logic [1:0] size, input bit uns, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold,
                          output logic [31:0] rdata, output bit err, output int lat);
        int t;
        req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1; rsp_ready = 1'b0;
        t = 0;
        while (!cur_ready() && t < 50) begin @(negedge clk); t++; end
        chk("accept_wait", 32'(t < 50), 32'd1);
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        while (!cur_valid() && lat < 50) begin
            req_valid = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            req_we = 1'($urandom); req_size = 2'($urandom);
            @(posedge clk); lat++; @(negedge clk);
        end
        chk("latency", 32'(lat), 32'(ws_of(int'(sel)) + 1));
        rdata = sel ? rdata_o[1] : rdata_o[0];
        err   = sel ? err_o[1] : err_o[0];
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(cur_valid()), 32'd1);
            chk("hold_ready", 32'(cur_ready()), 32'd0);
            chk("hold_rdata", sel ? rdata_o[1] : rdata_o[0], rdata);
            chk("hold_err", 32'(sel ? err_o[1] : err_o[0]), 32'(err));
        end
        rsp_ready = 1'b1; req_valid = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b0;
        chk("ready_after_rsp", 32'(cur_ready()), 32'd1);
        chk("valid_after_rsp", 32'(cur_valid()), 32'd0);
    endtask

    logic [31:0] rd;
    bit          er;
    int          lat;
    int          t;
    logic [31:0] ra;

    task automatic rand_txns(input int n, input bit hi_window);
        logic [31:0] a;
        logic [31:0] d;
        bit e;
        int l;
        int r;
        for (int j = 0; j < n; j++) begin
            r = $urandom_range(0, 9);
            if (r < 6 || (!hi_window && r < 9)) a = 32'($urandom_range(0, 63));
            else if (r < 9) a = 32'h3C0 + 32'($urandom_range(0, 79));
            else a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            do_txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 3), d, e, l);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Directed, 2 wait states
        do_txn(1'b1, 2'b10, 1'b0, 32'h010, 32'h87654321, 0, rd, er, lat);
        chk("st_lat", 32'(lat), 32'd3);
        chk("st_err", 32'(er), 32'd0);
        chk("st_rdata", rd, 32'd0);
        chk("mem10", 32'(dut0.mem_r[16]), 32'h21);
        chk("mem11", 32'(dut0.mem_r[17]), 32'h43);
        chk("mem12", 32'(dut0.mem_r[18]), 32'h65);
        chk("mem13", 32'(dut0.mem_r[19]), 32'h87);
        chk("model_mem13", 32'(mm[0][19]), 32'h87);
        do_txn(1'b0, 2'b00, 1'b0, 32'h013, 32'h0, 0, rd, er, lat);
        chk("lb_13", rd, 32'hFFFFFF87);
        do_txn(1'b0, 2'b00, 1'b1, 32'h013, 32'h0, 0, rd, er, lat);
        chk("lbu_13", rd, 32'h00000087);
        do_txn(1'b0, 2'b00, 1'b0, 32'h010, 32'h0, 0, rd, er, lat);
        chk("lb_10", rd, 32'h00000021);
        do_txn(1'b0, 2'b01, 1'b0, 32'h012, 32'h0, 0, rd, er, lat);
        chk("lh_12", rd, 32'hFFFF8765);
        do_txn(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 5, rd, er, lat);
        chk("lw_10_bp", rd, 32'h87654321);
        do_txn(1'b1, 2'b10, 1'b0, 32'h011, 32'hAAAAAAAA, 0, rd, er, lat);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_rdata", rd, 32'd0);
        chk("mis_mem11", 32'(dut0.mem_r[17]), 32'h43);
        chk("mis_mem12", 32'(dut0.mem_r[18]), 32'h65);
        do_txn(1'b1, 2'b10, 1'b0, 32'h3FE, 32'h55555555, 0, rd, er, lat);
        chk("range_err", 32'(er), 32'd1);
        do_txn(1'b0, 2'b11, 1'b0, 32'h010, 32'h0, 0, rd, er, lat);
        chk("size11_err", 32'(er), 32'd1);
        do_txn(1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, 0, rd, er, lat);
        chk("wrap_err", 32'(er), 32'd1);

        // Reset while a store to 0x020 is waiting with one wait state left
        do_txn(1'b1, 2'b00, 1'b0, 32'h020, 32'h5A, 0, rd, er, lat);
        req_we = 1'b1; req_size = 2'b00; req_uns = 1'b0; req_addr = 32'h020; req_wdata = 32'hC3;
        req_valid = 1'b1;
        t = 0;
        while (!cur_ready() && t < 50) begin @(negedge clk); t++; end
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ready_o[0]), 32'd0);
        chk("arst_valid", 32'(valid_o[0]), 32'd0);
        chk("arst_rdata", rdata_o[0], 32'd0);
        chk("arst_err", 32'(err_o[0]), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_mem20", 32'(dut0.mem_r[32]), 32'h5A);
        do_txn(1'b0, 2'b00, 1'b1, 32'h020, 32'h0, 0, rd, er, lat);
        chk("arst_load", rd, 32'h0000005A);

        // Fill the random windows, then random traffic
        for (int w = 0; w < 16; w++) begin
            do_txn(1'b1, 2'b10, 1'b0, 32'(4 * w), $urandom, 0, rd, er, lat);
            do_txn(1'b1, 2'b10, 1'b0, 32'h3C0 + 32'(4 * w), $urandom, 0, rd, er, lat);
        end
        rand_txns(80, 1'b1);

        // Zero wait states
        @(negedge clk); sel = 1'b1;
        @(negedge clk);
        do_txn(1'b1, 2'b10, 1'b0, 32'h008, 32'hDEADBEEF, 0, rd, er, lat);
        chk("ws0_st_lat", 32'(lat), 32'd1);
        do_txn(1'b0, 2'b10, 1'b0, 32'h008, 32'h0, 0, rd, er, lat);
        chk("ws0_lw", rd, 32'hDEADBEEF);
        chk("ws0_ld_lat", 32'(lat), 32'd1);
        do_txn(1'b0, 2'b01, 1'b1, 32'h00A, 32'h0, 0, rd, er, lat);
        chk("ws0_lhu", rd, 32'h0000DEAD);
        do_txn(1'b0, 2'b00, 1'b0, 32'h00B, 32'h0, 0, rd, er, lat);
        chk("ws0_lb", rd, 32'hFFFFFFDE);
        for (int w = 0; w < 16; w++) begin
            ra = 32'(4 * w);
            do_txn(1'b1, 2'b10, 1'b0, ra, $urandom, 0, rd, er, lat);
        end
        rand_txns(40, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
